// File: rtl/interrupt_controller.sv
// Interrupt controller: latches IRQ rising edges, hands one interrupt at a time to the CPU,
// and exposes ENABLE/PENDING/CTRL/STATUS over a word-addressed bus with registered reads.
module interrupt_controller #(
  parameter int unsigned BUS_W     = 32,
  parameter int unsigned NUM_IRQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned BASE_ADDR = 'h100
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [NUM_IRQ-1:0] i_IrqLines,
  output logic               o_IntRequest,
  output logic [ID_W-1:0]    o_IntNumber,
  output logic               o_IntPending,
  input  logic               i_IntAckAttended,
  input  logic               i_IntAckComplete,
  input  logic               i_WEnable,
  input  logic [BUS_W-1:0]   i_WAddr,
  input  logic [BUS_W-1:0]   i_WData,
  input  logic               i_REnable,
  input  logic [BUS_W-1:0]   i_RAddr,
  output logic [BUS_W-1:0]   o_RData,
  output logic               o_DataMemRdy
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d, first_id;
  logic [NUM_IRQ-1:0] prev_q, enable_q, enable_d, pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_edge, cand;
  logic               gie_q, gie_d;
  logic [BUS_W-1:0]   rdata_q, rdata_d, woff, roff;
  logic               rdy_q, rdy_d, w_hit, r_hit;
  logic               unused_wdata;

  assign irq_edge = i_IrqLines & ~prev_q;
  assign cand     = pending_q & enable_q & {NUM_IRQ{gie_q}};
  assign woff     = i_WAddr - BUS_W'(BASE_ADDR);
  assign roff     = i_RAddr - BUS_W'(BASE_ADDR);
  assign w_hit    = i_WEnable && (woff < BUS_W'(4));
  assign r_hit    = i_REnable && (roff < BUS_W'(4));

  assign unused_wdata = ^i_WData[BUS_W-1:NUM_IRQ];

  // Fixed priority: lowest index wins.
  always_comb begin
    first_id = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (cand[k]) first_id = ID_W'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      StIdle: begin
        if (|cand) begin
          state_d = StReq;
          id_d    = first_id;
        end
      end
      StReq:     if (i_IntAckAttended) state_d = StService;
      StService: if (i_IntAckComplete) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Edge set is applied last so a simultaneous new event survives W1C or ack clearing.
  always_comb begin
    pending_d = pending_q;
    enable_d  = enable_q;
    gie_d     = gie_q;
    if (w_hit && woff[1:0] == 2'd0) enable_d = i_WData[NUM_IRQ-1:0];
    if (w_hit && woff[1:0] == 2'd1) pending_d = pending_d & ~i_WData[NUM_IRQ-1:0];
    if (w_hit && woff[1:0] == 2'd2) gie_d = i_WData[0];
    if (state_q == StReq && i_IntAckAttended) pending_d[id_q] = 1'b0;
    pending_d = pending_d | irq_edge;
  end

  // Writes anywhere are acknowledged; only mapped reads are.
  always_comb begin
    rdata_d = rdata_q;
    rdy_d   = i_WEnable || r_hit;
    if (r_hit) begin
      rdata_d = '0;
      case (roff[1:0])
        2'd0:    rdata_d[NUM_IRQ-1:0] = enable_q;
        2'd1:    rdata_d[NUM_IRQ-1:0] = pending_q;
        2'd2:    rdata_d[0]           = gie_q;
        default: rdata_d[ID_W+1:0]    = {state_q, id_q};
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= StIdle;
      id_q      <= '0;
      prev_q    <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      gie_q     <= 1'b0;
      rdata_q   <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      prev_q    <= i_IrqLines;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      gie_q     <= gie_d;
      rdata_q   <= rdata_d;
      rdy_q     <= rdy_d;
    end
  end

  assign o_IntRequest = (state_q == StReq);
  assign o_IntPending = (state_q == StReq);
  assign o_IntNumber  = id_q;
  assign o_RData      = rdata_q;
  assign o_DataMemRdy = rdy_q;

endmodule
